ibex_register_file_storage: RTL and testbench

- Flop-based register array on the consuming end of the regfile one-hot decode path.
- Takes the one-hot write-enable vector and the one-hot read selects generated upstream.
- Performs the writes and the one-hot AND-OR read muxing, cross-checks against a binary-indexed mux, and verifies each write by reading it back on the next cycle.
- Raises a sticky, acknowledged error alongside the upstream decode error.

---
 rtl/ibex_register_file_storage_pkg.sv | 7 +
 rtl/ibex_register_file_storage_rdmux.sv | 23 ++
 rtl/ibex_register_file_storage.sv | 84 ++++++++
 tb/tb_ibex_register_file_storage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ibex_register_file_storage_pkg.sv
// ibex_pkg: cause-bit indices and cause vector type shared by the regfile storage.
package ibex_pkg;
    localparam int REGFILE_ERR_RDA = 0;
    localparam int REGFILE_ERR_RDB = 1;
    localparam int REGFILE_ERR_WRV = 2;
    typedef logic [2:0] regfile_err_t;
endpackage

// File: rtl/ibex_register_file_storage_rdmux.sv
// ibex_register_file_rdmux: one-hot AND-OR read mux cross-checked against a binary mux.
module ibex_register_file_rdmux #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int NumWords  = 2 ** AddrWidth,
    parameter bit MuxCheck  = 1'b0
) (
    input  logic [NumWords-1:0][DataWidth-1:0] words,
    input  logic [AddrWidth-1:0]               raddr,
    input  logic [NumWords-1:0]                raddr_onehot,
    output logic [DataWidth-1:0]               rdata,
    output logic                               mismatch
);
    logic [DataWidth-1:0] rdata_onehot;
    logic [DataWidth-1:0] rdata_bin;
    always_comb begin
        rdata_onehot = '0;
        for (int i = 0; i < NumWords; i++) rdata_onehot |= words[i] & {DataWidth{raddr_onehot[i]}};
    end
    assign rdata_bin = words[raddr];
    assign rdata     = MuxCheck ? rdata_onehot : rdata_bin;
    assign mismatch  = MuxCheck && (rdata_onehot != rdata_bin);
endmodule

// File: rtl/ibex_register_file_storage.sv
// ibex_register_file_storage: flop register array with read-mux cross-check,
// next-cycle write readback verify and a sticky acknowledged error latch.
module ibex_register_file_storage
    import ibex_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 5,
    parameter int NumWords      = 2 ** AddrWidth,
    parameter bit RdataMuxCheck = 1'b0,
    parameter bit WriteVerify   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] raddr_a_i,
    input  logic [NumWords-1:0]  raddr_onehot_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [AddrWidth-1:0] raddr_b_i,
    input  logic [NumWords-1:0]  raddr_onehot_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic [AddrWidth-1:0] waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    input  logic [NumWords-1:0]  we_onehot_a_i,
    input  logic                 err_ack_i,
    output logic                 err_o,
    output logic [2:0]           err_cause_o
);
    logic [NumWords-1:0][DataWidth-1:0] mem_q;
    logic                               vld_q;
    logic [AddrWidth-1:0]               waddr_q;
    logic [DataWidth-1:0]               wdata_q;
    logic                               mis_a, mis_b, wr_verify;
    regfile_err_t                       ev, cause_q;

    // Word 0 is only ever loaded by reset, so it stays hardwired to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < NumWords; i++) if (i != 0 && we_onehot_a_i[i]) mem_q[i] <= wdata_a_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            vld_q   <= WriteVerify && (|we_onehot_a_i[NumWords-1:1]);
            waddr_q <= waddr_a_i;
            wdata_q <= wdata_a_i;
        end
    end

    assign wr_verify = vld_q && (mem_q[waddr_q] != ((waddr_q == '0) ? '0 : wdata_q));

    ibex_register_file_rdmux #(
        .DataWidth(DataWidth), .AddrWidth(AddrWidth), .NumWords(NumWords), .MuxCheck(RdataMuxCheck)
    ) u_rdmux_a (
        .words(mem_q), .raddr(raddr_a_i), .raddr_onehot(raddr_onehot_a_i), .rdata(rdata_a_o), .mismatch(mis_a)
    );

    ibex_register_file_rdmux #(
        .DataWidth(DataWidth), .AddrWidth(AddrWidth), .NumWords(NumWords), .MuxCheck(RdataMuxCheck)
    ) u_rdmux_b (
        .words(mem_q), .raddr(raddr_b_i), .raddr_onehot(raddr_onehot_b_i), .rdata(rdata_b_o), .mismatch(mis_b)
    );

    always_comb begin
        ev                  = '0;
        ev[REGFILE_ERR_RDA] = mis_a;
        ev[REGFILE_ERR_RDB] = mis_b;
        ev[REGFILE_ERR_WRV] = wr_verify;
    end

    // A fresh event outranks a simultaneous acknowledge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cause_q <= '0;
        else cause_q <= ev | (err_ack_i ? '0 : cause_q);
    end

    assign err_o       = |cause_q;
    assign err_cause_o = cause_q;
endmodule

// File: tb/tb_ibex_register_file_storage.sv
// tb_ibex_register_file_storage: randomized + directed scoreboard bench against a
// behavioural array model of the register file storage (one-hot mux check enabled).
module tb_ibex_register_file_storage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  raddr_a, raddr_b, waddr;
    logic [31:0] oh_a, oh_b, we, wdata, rdata_a, rdata_b;
    logic        ack, err;
    logic [2:0]  cause;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        err;
        logic [2:0]  cause;
    } exp_t;

    exp_t        q[$];
    exp_t        e_m;
    logic [31:0] m[32];
    bit          pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic [2:0]  mc;
    int          tests = 0;
    int          fails = 0;

    ibex_register_file_storage #(.RdataMuxCheck(1'b1), .WriteVerify(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_a_i(raddr_a), .raddr_onehot_a_i(oh_a), .rdata_a_o(rdata_a),
        .raddr_b_i(raddr_b), .raddr_onehot_b_i(oh_b), .rdata_b_o(rdata_b),
        .waddr_a_i(waddr), .wdata_a_i(wdata), .we_onehot_a_i(we),
        .err_ack_i(ack), .err_o(err), .err_cause_o(cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] oh(input logic [4:0] a);
        return 32'd1 << a;
    endfunction

    function automatic logic [31:0] oh_read(input logic [31:0] sel);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) if (sel[i]) r |= m[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = '0;
        pv = 0;
        pa = '0;
        pd = '0;
        mc = '0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict outputs for this cycle, then advance the model over the edge.
    task automatic cycle(input bit rst, input logic [4:0] ra, input logic [31:0] oha,
                         input logic [4:0] rb, input logic [31:0] ohb, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] w, input bit a);
        logic [2:0] ev;
        rst_n = rst; raddr_a = ra; oh_a = oha; raddr_b = rb; oh_b = ohb;
        waddr = wa; wdata = wd; we = w; ack = a;
        if (!rst) model_clear();
        q.push_back('{oh_read(oha), oh_read(ohb), |mc, mc});
        @(posedge clk);
        if (rst) begin
            ev[2] = pv && (m[pa] != ((pa == 0) ? 32'd0 : pd));
            ev[1] = oh_read(ohb) != m[rb];
            ev[0] = oh_read(oha) != m[ra];
            mc = ev | (a ? 3'b000 : mc);
            pv = |w[31:1];
            pa = wa;
            pd = wd;
            for (int i = 1; i < 32; i++) if (w[i]) m[i] = wd;
        end
        #1;
    endtask

    task automatic idle(input bit a);
        cycle(1, 0, oh(0), 0, oh(0), 0, 0, 0, a);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] w, input logic [31:0] wd);
        cycle(1, 0, oh(0), 0, oh(0), wa, wd, w, 0);
    endtask

    task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
        cycle(1, ra, oh(ra), rb, oh(rb), 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_m = q.pop_front();
            chk("rdata_a", rdata_a, e_m.ra);
            chk("rdata_b", rdata_b, e_m.rb);
            chk("err_o", 32'(err), 32'(e_m.err));
            chk("err_cause", 32'(cause), 32'(e_m.cause));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ra, rb, wa;
        logic [31:0] oha, ohb, w;
        rst_n = 0; raddr_a = 0; raddr_b = 0; oh_a = 1; oh_b = 1;
        waddr = 0; wdata = 0; we = 0; ack = 0;
        model_clear();
        @(posedge clk); #1;
        cycle(0, 0, oh(0), 0, oh(0), 0, 0, 0, 0);
        cycle(0, 0, oh(0), 0, oh(0), 0, 0, 0, 0);
        wr(5, oh(5), 32'hDEADBEEF);
        rd(5, 0);
        idle(0);
        wr(0, oh(0), 32'hFFFFFFFF);
        rd(0, 0);
        idle(0);
        wr(3, oh(3), 32'h11);
        wr(4, oh(4), 32'h22);
        cycle(1, 0, oh(0), 3, oh(4), 0, 0, 0, 0);
        idle(0);
        idle(1);
        idle(0);
        wr(6, oh(7), 32'hA5);
        idle(0);
        idle(0);
        rd(7, 6);
        idle(1);
        cycle(1, 0, oh(0), 3, oh(4), 0, 0, 0, 0);
        cycle(1, 3, oh(4), 0, oh(0), 0, 0, 0, 1);
        idle(0);
        idle(1);
        wr(1, oh(1), 32'd1);
        wr(2, oh(2), 32'd2);
        wr(1, oh(1), 32'd3);
        rd(1, 2);
        idle(0);
        wr(9, oh(9), 32'h1234);
        cycle(0, 9, oh(9), 10, oh(10), 10, 32'h5678, oh(10), 0);
        cycle(0, 0, oh(0), 0, oh(0), 0, 0, 0, 0);
        rd(9, 10);
        idle(0);
        idle(0);
        for (int n = 0; n < 400; n++) begin
            ra  = 5'($urandom);
            rb  = 5'($urandom);
            wa  = 5'($urandom);
            oha = ($urandom_range(0, 9) == 0) ? $urandom : oh(ra);
            ohb = ($urandom_range(0, 9) == 0) ? $urandom : oh(rb);
            w   = ($urandom_range(0, 2) == 0) ? 32'd0 :
                  ($urandom_range(0, 9) == 0) ? ($urandom & $urandom) : oh(wa);
            cycle($urandom_range(0, 99) != 0, ra, oha, rb, ohb, wa, $urandom, w, $urandom_range(0, 4) == 0);
        end
        @(posedge clk); #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
